// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM generator: FSM encoding, default timing
// constants and the command clamp.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

  localparam int unsigned PERIOD_TICKS_DEF = 625;
  localparam int unsigned CNT_W_DEF        = 10;
  localparam int unsigned MIN_PW_DEF       = 31;
  localparam int unsigned MAX_PW_DEF       = 63;
  localparam int unsigned STEP_DEF         = 1;

  function automatic int unsigned clamp_pw(input int unsigned v,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pwm_ramp.sv
// Holds the target and active pulse widths; at each wrap the active width
// moves at most STEP toward the target, using the target from before any load.
module pwm_ramp #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned MIN_PW = 31,
  parameter int unsigned STEP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrap,
  input  logic             load,
  input  logic [CNT_W-1:0] load_pw,
  output logic [CNT_W-1:0] cur_pw,
  output logic [CNT_W-1:0] cur_pw_nxt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] INIT_W = CNT_W'(MIN_PW);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] target_nxt;

  always_comb begin
    cur_pw_nxt = cur_pw;
    target_nxt = load ? load_pw : target;
    // Differences are compared against STEP so the add/subtract never wraps.
    if (wrap) begin
      if (cur_pw < target) begin
        cur_pw_nxt = ((target - cur_pw) > STEP_W) ? (cur_pw + STEP_W) : target;
      end else if (cur_pw > target) begin
        cur_pw_nxt = ((cur_pw - target) > STEP_W) ? (cur_pw - STEP_W) : target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= INIT_W;
      cur_pw <= INIT_W;
      busy   <= 1'b0;
    end else begin
      target <= target_nxt;
      cur_pw <= cur_pw_nxt;
      busy   <= (cur_pw_nxt != target_nxt);
    end
  end

endmodule

// File: rtl/pwm_servo_gen.sv
// Servo PWM generator: tick-enabled period counter, IDLE/RUN/DRAIN control,
// one-deep command slot and ramp-limited pulse width.
module pwm_servo_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned MIN_PW       = MIN_PW_DEF,
  parameter int unsigned MAX_PW       = MAX_PW_DEF,
  parameter int unsigned STEP         = STEP_DEF
) (
  input  logic             clock_test,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             cmd_valid_i,
  input  logic [CNT_W-1:0] cmd_pw_i,
  output logic             cmd_ready_o,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cur_pw_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PW);

  pwm_state_t       state;
  pwm_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pend_pw;
  logic [CNT_W-1:0] cur_pw_nxt;
  logic             pend_full;
  logic             wrap;
  logic             load;
  logic             accept;
  logic             pwm_nxt;

  // Handshake: a command transfers on any cycle with cmd_valid_i && cmd_ready_o.
  // cmd_ready_o is low exactly while the pending slot is full; the slot empties
  // into the target at a wrap (or at any tick while idle).
  assign cmd_ready_o = !pend_full;
  assign accept      = cmd_valid_i && !pend_full;
  assign load        = pend_full && (wrap || (state == IDLE && tick_i));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap      = tick_i && (cnt == LAST_CNT) && (state != IDLE);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tick_i && en_i) state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (tick_i) cnt_nxt = wrap ? '0 : (cnt + 1'b1);
        // Without en_i the period in flight always finishes before stopping.
        if (en_i) state_nxt = RUN;
        else      state_nxt = wrap ? IDLE : DRAIN;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    pwm_nxt = (state_nxt != IDLE) && (cnt_nxt < cur_pw_nxt);
  end

  always_ff @(posedge clock_test or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
      pend_full      <= 1'b0;
      pend_pw        <= MIN_W;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      pwm_o          <= pwm_nxt;
      period_start_o <= wrap;
      if (accept) begin
        pend_full <= 1'b1;
        pend_pw   <= CNT_W'(clamp_pw(32'(cmd_pw_i), MIN_PW, MAX_PW));
      end else if (load) begin
        pend_full <= 1'b0;
      end
    end
  end

  pwm_ramp #(
    .CNT_W  (CNT_W),
    .MIN_PW (MIN_PW),
    .STEP   (STEP)
  ) u_ramp (
    .clk        (clock_test),
    .rst_n      (rstn),
    .wrap       (wrap),
    .load       (load),
    .load_pw    (pend_pw),
    .cur_pw     (cur_pw_o),
    .cur_pw_nxt (cur_pw_nxt),
    .busy       (busy_o)
  );

endmodule

// File: tb/tb_pwm_servo_gen.sv
// Bench for pwm_servo_gen: directed steps plus random traffic, every cycle
// compared against a period/width model of the servo generator.
module tb_pwm_servo_gen;

  localparam int P    = 10;
  localparam int W    = 10;
  localparam int MINP = 2;
  localparam int MAXP = 8;
  localparam int STP  = 1;

  logic         clock_test = 1'b0;
  logic         rstn = 1'b0;
  logic         tick_i = 1'b0;
  logic         en_i = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic [W-1:0] cmd_pw_i = '0;
  logic         cmd_ready_o;
  logic         pwm_o;
  logic         period_start_o;
  logic         busy_o;
  logic [W-1:0] cur_pw_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_mode = 0;

  // Model: running flag, tick count within the period, widths, command slot.
  bit m_active;
  bit m_pend;
  bit m_ps;
  int m_cnt;
  int m_cur;
  int m_tgt;
  int m_pend_v;

  pwm_servo_gen #(
    .PERIOD_TICKS (P),
    .CNT_W        (W),
    .MIN_PW       (MINP),
    .MAX_PW       (MAXP),
    .STEP         (STP)
  ) dut (
    .clock_test     (clock_test),
    .rstn           (rstn),
    .tick_i         (tick_i),
    .en_i           (en_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_pw_i       (cmd_pw_i),
    .cmd_ready_o    (cmd_ready_o),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .busy_o         (busy_o),
    .cur_pw_o       (cur_pw_o)
  );

  always #5 clock_test = ~clock_test;

  function automatic int clampi(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  function automatic int toward(input int c, input int t);
    if (c < t) return (c + STP < t) ? c + STP : t;
    if (c > t) return (c - STP > t) ? c - STP : t;
    return c;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_ps     = 1'b0;
    m_cnt    = 0;
    m_cur    = MINP;
    m_tgt    = MINP;
    m_pend_v = MINP;
  endtask

  task automatic model_clock();
    bit wrap;
    bit had;
    if (!rstn) begin
      model_reset();
      return;
    end
    wrap = tick_i && m_active && (m_cnt == P - 1);
    had  = m_pend;
    if (tick_i) begin
      if (!m_active) begin
        if (had) begin m_tgt = m_pend_v; m_pend = 1'b0; end
        if (en_i) begin m_active = 1'b1; m_cnt = 0; end
      end else if (wrap) begin
        m_cur = toward(m_cur, m_tgt);
        if (had) begin m_tgt = m_pend_v; m_pend = 1'b0; end
        m_cnt    = 0;
        m_active = en_i;
      end else begin
        m_cnt++;
      end
    end
    if (cmd_valid_i && !had) begin
      m_pend   = 1'b1;
      m_pend_v = clampi(int'(cmd_pw_i));
    end
    m_ps = wrap;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event (cycle %0d)", tag, cyc);
  endtask

  task automatic check_all();
    chk("pwm_o", 32'(pwm_o), 32'(m_active && (m_cnt < m_cur)));
    chk("period_start_o", 32'(period_start_o), 32'(m_ps));
    chk("cmd_ready_o", 32'(cmd_ready_o), 32'(!m_pend));
    chk("busy_o", 32'(busy_o), 32'(m_cur != m_tgt));
    chk("cur_pw_o", 32'(cur_pw_o), 32'(m_cur));
  endtask

  task automatic step();
    case (tick_mode)
      0:       tick_i = 1'b1;
      1:       tick_i = (cyc % 4 == 0);
      default: tick_i = ($urandom_range(0, 2) == 0);
    endcase
    @(posedge clock_test);
    model_clock();
    @(negedge clock_test);
    cyc++;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int pw);
    int n = 0;
    while (!cmd_ready_o && n < 200) begin step(); n++; end
    if (n >= 200) timeout("send_ready");
    cmd_valid_i = 1'b1;
    cmd_pw_i    = W'(pw);
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic sync_cnt(input int c);
    int n = 0;
    while (!(m_active && m_cnt == c) && n < 200) begin step(); n++; end
    if (n >= 200) timeout("sync_cnt");
  endtask

  // Counts high cycles over one period (len cycles), starting at a DUT period start.
  task automatic measure_high(input string tag, input int len, input int exp_hi);
    int n = 0;
    int hi;
    while (!period_start_o && n < 200) begin step(); n++; end
    if (n >= 200) timeout({tag, "_align"});
    hi = int'(pwm_o);
    repeat (len - 1) begin step(); hi += int'(pwm_o); end
    chk(tag, 32'(hi), 32'(exp_hi));
  endtask

  initial begin
    int hi;
    int ps_cnt;
    int n;
    model_reset();
    rstn = 1'b0;
    @(negedge clock_test);
    check_all();
    run(2);
    rstn = 1'b1;
    run(2);

    // Running at minimum width.
    en_i = 1'b1;
    run(3);
    measure_high("base_high", P, MINP);
    chk("base_cur", 32'(cur_pw_o), 32'(MINP));
    chk("base_busy", 32'(busy_o), 32'd0);

    // Command 5 mid-period, ramp 2 -> 5.
    sync_cnt(4);
    cmd_valid_i = 1'b1;
    cmd_pw_i    = W'(5);
    step();
    cmd_valid_i = 1'b0;
    chk("ready_drop", 32'(cmd_ready_o), 32'd0);
    run(45);
    chk("ramp_cur5", 32'(cur_pw_o), 32'd5);
    chk("ramp_busy5", 32'(busy_o), 32'd0);
    measure_high("ramp_high5", P, 5);

    // Clamping both ways.
    send(20);
    run(50);
    chk("clamp_hi_cur", 32'(cur_pw_o), 32'(MAXP));
    send(0);
    run(80);
    chk("clamp_lo_cur", 32'(cur_pw_o), 32'(MINP));

    // Command accepted on the wrap cycle waits one full period.
    sync_cnt(P - 1);
    cmd_valid_i = 1'b1;
    cmd_pw_i    = W'(6);
    step();
    cmd_valid_i = 1'b0;
    run(5);
    chk("wrap_cmd_hold", 32'(busy_o), 32'd0);
    run(5);
    chk("wrap_cmd_load", 32'(busy_o), 32'd1);
    chk("wrap_cmd_cur", 32'(cur_pw_o), 32'(MINP));

    // Drain: en_i falls at cnt=1 with width 5.
    send(5);
    run(60);
    chk("drain_cur", 32'(cur_pw_o), 32'd5);
    sync_cnt(1);
    en_i = 1'b0;
    hi = 0;
    repeat (P - 1) begin step(); hi += int'(pwm_o); end
    chk("drain_tail_high", 32'(hi), 32'd3);
    ps_cnt = 0;
    repeat (15) begin step(); ps_cnt += int'(period_start_o) + int'(pwm_o); end
    chk("idle_quiet", 32'(ps_cnt), 32'd0);
    en_i = 1'b1;
    run(5);
    en_i = 1'b0;
    run(2);
    en_i = 1'b1;
    measure_high("drain_return", P, 5);

    // Slow tick stretches each high time.
    tick_mode = 1;
    run(8);
    measure_high("slow_tick_high", 4 * P, 20);
    tick_mode = 0;

    // Asynchronous reset in the middle of a high pulse.
    n = 0;
    while (!(m_active && m_cnt == 1) && n < 200) begin step(); n++; end
    if (n >= 200) timeout("async_align");
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock_test);
    run(1);
    rstn = 1'b1;
    run(3);

    // Random traffic.
    tick_mode = 2;
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) en_i = !en_i;
      cmd_valid_i = ($urandom_range(0, 5) == 0);
      cmd_pw_i    = W'($urandom_range(0, 15));
      rstn        = ($urandom_range(0, 399) != 0);
      step();
    end
    rstn        = 1'b1;
    cmd_valid_i = 1'b0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
